// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalise/round pipeline for the FP adder result path.
// S1 normalises the raw significand, S2 rounds and holds the output.
module fp_normalize_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+3:0] in_mant,
    input  logic             in_sticky,
    input  logic [1:0]       in_rmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact
);

    localparam int XW  = EXP_W + 2;
    localparam int NW  = MAN_W + 3;
    localparam int LZW = $clog2(NW + 1);

    localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Leading-zero count; the highest set bit is the last one the loop sees.
    function automatic logic [LZW-1:0] f_lzc(input logic [NW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(NW);
        for (int i = 0; i < NW; i++) begin
            if (v[i]) n = LZW'(NW - 1 - i);
        end
        return n;
    endfunction

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [EXP_W:0]   r_s1_exp;
    logic [MAN_W-1:0] r_s1_frac;
    logic             r_s1_g;
    logic             r_s1_r;
    logic             r_s1_s;
    logic             r_s1_zero;
    logic             r_s1_uf;
    logic [1:0]       r_s1_rmode;

    logic             r_out_valid;
    logic             r_out_sign;
    logic [EXP_W-1:0] r_out_exp;
    logic [MAN_W-1:0] r_out_frac;
    logic             r_out_zero;
    logic             r_out_ovf;
    logic             r_out_uf;
    logic             r_out_inex;

    logic w_s2_load;

    assign w_s2_load = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;

    logic             w_carry;
    logic [NW-1:0]    w_m;
    logic [NW-1:0]    w_shl;
    logic [LZW-1:0]   w_lz;
    logic [XW-1:0]    w_exp_n;
    logic [MAN_W-1:0] w_frac_n;
    logic             w_g_n;
    logic             w_r_n;
    logic             w_s_n;
    logic             w_in_zero;
    logic             w_flush;

    // S1: align the significand so the hidden bit is set, track the exponent.
    always_comb begin
        w_carry   = in_mant[MAN_W+3];
        w_m       = in_mant[NW-1:0];
        w_lz      = f_lzc(w_m);
        w_shl     = w_m << w_lz;
        w_in_zero = (in_mant == '0) && !in_sticky;
        if (w_carry) begin
            w_exp_n  = {2'b00, in_exp} + XW'(1);
            w_frac_n = in_mant[MAN_W+2:3];
            w_g_n    = in_mant[2];
            w_r_n    = in_mant[1];
            w_s_n    = in_mant[0] | in_sticky;
        end else begin
            w_exp_n  = {2'b00, in_exp} - XW'(w_lz);
            w_frac_n = w_shl[NW-2:2];
            w_g_n    = w_shl[1];
            w_r_n    = w_shl[0];
            w_s_n    = in_sticky;
        end
        // Sticky-only residue has no hidden bit to normalise to: flush it.
        w_flush = !w_in_zero &&
                  (w_exp_n[XW-1] || (w_exp_n == '0) ||
                   (in_exp == '0) ||
                   (!w_carry && !w_shl[NW-1]));
    end

    // S1 register: capture the normalised beat when the stage can advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_r     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_uf    <= 1'b0;
            r_s1_rmode <= RM_RNE;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= in_sign;
                r_s1_rmode <= in_rmode;
                r_s1_zero  <= w_in_zero || w_flush;
                r_s1_uf    <= w_flush;
                if (w_in_zero || w_flush) begin
                    r_s1_exp  <= '0;
                    r_s1_frac <= '0;
                    r_s1_g    <= 1'b0;
                    r_s1_r    <= 1'b0;
                    r_s1_s    <= 1'b0;
                end else begin
                    r_s1_exp  <= w_exp_n[EXP_W:0];
                    r_s1_frac <= w_frac_n;
                    r_s1_g    <= w_g_n;
                    r_s1_r    <= w_r_n;
                    r_s1_s    <= w_s_n;
                end
            end
        end
    end

    logic             w_inc;
    logic             w_inc_rne;
    logic             w_cy_rne;
    logic             w_grs;
    logic             w_away;
    logic             w_ovf;
    logic [MAN_W:0]   w_sum;
    logic [EXP_W:0]   w_exp_chk;
    logic             w_o_sign;
    logic [EXP_W-1:0] w_o_exp;
    logic [MAN_W-1:0] w_o_frac;
    logic             w_o_zero;
    logic             w_o_ovf;
    logic             w_o_uf;
    logic             w_o_inex;

    // S2: rounding increment, overflow saturation and flag generation.
    always_comb begin
        w_grs     = r_s1_g | r_s1_r | r_s1_s;
        w_inc_rne = r_s1_g & (r_s1_r | r_s1_s | r_s1_frac[0]);
        w_inc     = 1'b0;
        unique case (r_s1_rmode)
            RM_RNE: w_inc = w_inc_rne;
            RM_RTZ: w_inc = 1'b0;
            RM_RUP: w_inc = !r_s1_sign && w_grs;
            RM_RDN: w_inc = r_s1_sign && w_grs;
            default: w_inc = 1'b0;
        endcase
        w_sum    = {1'b0, r_s1_frac} + {{MAN_W{1'b0}}, w_inc};
        w_cy_rne = w_inc_rne & (&r_s1_frac);
        // Overflow is judged on the nearest-rounded magnitude as well, so
        // truncating modes still report it and saturate to max finite.
        w_exp_chk = r_s1_exp +
                    {{EXP_W{1'b0}}, (w_sum[MAN_W] | w_cy_rne)};
        w_ovf  = (w_exp_chk >= EMAX);
        w_away = (r_s1_rmode == RM_RNE) ||
                 ((r_s1_rmode == RM_RUP) && !r_s1_sign) ||
                 ((r_s1_rmode == RM_RDN) && r_s1_sign);

        w_o_sign = r_s1_sign;
        w_o_zero = 1'b0;
        w_o_ovf  = 1'b0;
        w_o_uf   = 1'b0;
        w_o_exp  = r_s1_exp[EXP_W-1:0] + EXP_W'(w_sum[MAN_W]);
        w_o_frac = w_sum[MAN_W-1:0];
        w_o_inex = w_grs;
        if (r_s1_zero) begin
            w_o_zero = 1'b1;
            w_o_uf   = r_s1_uf;
            w_o_inex = r_s1_uf;
            w_o_exp  = '0;
            w_o_frac = '0;
        end else if (w_ovf) begin
            w_o_ovf  = 1'b1;
            w_o_inex = 1'b1;
            if (w_away) begin
                w_o_exp  = '1;
                w_o_frac = '0;
            end else begin
                w_o_exp  = {{(EXP_W-1){1'b1}}, 1'b0};
                w_o_frac = '1;
            end
        end
    end

    // S2 register: output fields update only when a new beat moves in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_zero  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_uf    <= 1'b0;
            r_out_inex  <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign <= w_o_sign;
                r_out_exp  <= w_o_exp;
                r_out_frac <= w_o_frac;
                r_out_zero <= w_o_zero;
                r_out_ovf  <= w_o_ovf;
                r_out_uf   <= w_o_uf;
                r_out_inex <= w_o_inex;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_sign      = r_out_sign;
    assign out_exp       = r_out_exp;
    assign out_frac      = r_out_frac;
    assign out_zero      = r_out_zero;
    assign out_overflow  = r_out_ovf;
    assign out_underflow = r_out_uf;
    assign out_inexact   = r_out_inex;

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Scoreboard bench for fp_normalize_round_pipe: directed vectors,
// backpressure hold/burst and mid-flight reset.
module tb_fp_normalize_round_pipe;

    typedef logic [35:0] res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_sticky;
    logic [1:0]  in_rmode;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    fp_normalize_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_sticky    (in_sticky),
        .in_rmode     (in_rmode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_frac     (out_frac),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    res_t w_obs;
    assign w_obs = {out_sign, out_exp, out_frac,
                    out_zero, out_overflow, out_underflow, out_inexact};

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_pop = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic res_t E(input bit s, input logic [7:0] e,
                               input logic [22:0] f, input bit z,
                               input bit o, input bit u, input bit i);
        return {s, e, f, z, o, u, i};
    endfunction

    function automatic logic [26:0] M(input bit c, input bit h,
                                      input logic [22:0] f,
                                      input bit g, input bit r);
        return {c, h, f, g, r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic send(input bit s, input logic [7:0] e,
                        input logic [26:0] m, input bit st,
                        input logic [1:0] rm, input res_t x);
        bit rdy;
        bit done;
        done      = 0;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_sticky = st;
        in_rmode  = rm;
        in_valid  = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1 rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                n_acc++;
                sb.push_back(x);
                done = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready 0 required 1");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_left", sb.size(), 0);
    endtask

    // Monitor: pops on every output transfer, checks hold while stalled.
    initial begin : mon
        res_t prev;
        res_t req;
        bit   stalled;
        stalled = 0;
        prev    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stalled = 0;
            end else begin
                if (out_valid && stalled) chk("hold", w_obs, prev);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got %h required none",
                                 w_obs);
                    end else begin
                        req = sb.pop_front();
                        chk($sformatf("result%0d", n_pop), w_obs, req);
                    end
                    n_pop++;
                    last_pop_cyc = cyc;
                end
                stalled = out_valid && !out_ready;
                prev    = w_obs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int pbase;
        int abase;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_sticky = 1'b0;
        in_rmode  = RNE;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_fields", w_obs, 0);
        reset = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // carry path plus two-edge latency
        send(0, 8'h7F, M(1, 1, 23'h0, 0, 0), 0, RNE,
             E(0, 8'h80, 23'h400000, 0, 0, 0, 0));
        #2 chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        #2 chk("lat_edge2", out_valid, 1);
        @(negedge clk);

        // cancellation and flush
        send(0, 8'h7F, M(0, 0, 23'h1, 0, 0), 0, RNE,
             E(0, 8'h68, 23'h0, 0, 0, 0, 0));
        send(0, 8'h10, M(0, 0, 23'h1, 0, 0), 0, RNE,
             E(0, 8'h00, 23'h0, 1, 0, 1, 1));
        send(0, 8'h00, M(0, 1, 23'h3, 0, 0), 0, RNE,
             E(0, 8'h00, 23'h0, 1, 0, 1, 1));
        // ties and modes
        send(0, 8'h7F, M(0, 1, 23'h1, 1, 0), 0, RNE,
             E(0, 8'h7F, 23'h2, 0, 0, 0, 1));
        send(0, 8'h7F, M(0, 1, 23'h0, 1, 0), 0, RNE,
             E(0, 8'h7F, 23'h0, 0, 0, 0, 1));
        send(0, 8'h7F, M(0, 1, 23'h1, 1, 0), 0, RTZ,
             E(0, 8'h7F, 23'h1, 0, 0, 0, 1));
        send(0, 8'h7F, M(0, 1, 23'h1, 1, 0), 0, RUP,
             E(0, 8'h7F, 23'h2, 0, 0, 0, 1));
        send(1, 8'h7F, M(0, 1, 23'h1, 0, 1), 0, RDN,
             E(1, 8'h7F, 23'h2, 0, 0, 0, 1));
        send(1, 8'h7F, M(0, 1, 23'h1, 0, 1), 0, RUP,
             E(1, 8'h7F, 23'h1, 0, 0, 0, 1));
        send(0, 8'h7F, M(0, 1, 23'h5, 0, 0), 1, RNE,
             E(0, 8'h7F, 23'h5, 0, 0, 0, 1));
        send(0, 8'h7F, M(1, 1, 23'h1, 0, 1), 0, RNE,
             E(0, 8'h80, 23'h400001, 0, 0, 0, 1));
        send(1, 8'h55, M(0, 0, 23'h0, 0, 0), 0, RDN,
             E(1, 8'h00, 23'h0, 1, 0, 0, 0));
        // round carry and overflow
        send(0, 8'h7E, M(0, 1, 23'h7FFFFF, 1, 1), 0, RNE,
             E(0, 8'h7F, 23'h0, 0, 0, 0, 1));
        send(0, 8'hFE, M(0, 1, 23'h7FFFFF, 1, 1), 0, RNE,
             E(0, 8'hFF, 23'h0, 0, 1, 0, 1));
        send(0, 8'hFE, M(0, 1, 23'h7FFFFF, 1, 1), 0, RTZ,
             E(0, 8'hFE, 23'h7FFFFF, 0, 1, 0, 1));
        send(0, 8'hFE, M(0, 1, 23'h7FFFFF, 0, 1), 0, RUP,
             E(0, 8'hFF, 23'h0, 0, 1, 0, 1));
        send(1, 8'hFE, M(0, 1, 23'h7FFFFF, 1, 1), 0, RUP,
             E(1, 8'hFE, 23'h7FFFFF, 0, 1, 0, 1));
        drain();

        // backpressure: 5 beats, output stalled for 6 cycles
        out_ready = 1'b0;
        abase = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(0, 8'h40 + 8'(i), M(0, 1, 23'(i + 1), 0, 0), 0,
                         RNE, E(0, 8'h40 + 8'(i), 23'(i + 1), 0, 0, 0, 0));
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_accepted", n_acc - abase, 2);
                pbase = n_pop;
                c0 = cyc;
                out_ready = 1'b1;
                for (int t = 0; t < 40 && n_pop < pbase + 5; t++)
                    @(negedge clk);
                chk("bp_burst_pops", n_pop - pbase, 5);
                chk("bp_burst_span", last_pop_cyc - c0, 4);
            end
        join
        drain();

        // reset with two beats in flight
        out_ready = 1'b0;
        send(0, 8'h20, M(0, 1, 23'h11, 0, 0), 0, RNE,
             E(0, 8'h20, 23'h11, 0, 0, 0, 0));
        send(0, 8'h21, M(0, 1, 23'h22, 0, 0), 0, RNE,
             E(0, 8'h21, 23'h22, 0, 0, 0, 0));
        #4 reset = 1'b1;
        sb.delete();
        #1 chk("rst2_valid", out_valid, 0);
        chk("rst2_fields", w_obs, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        #1 chk("rst2_in_ready", in_ready, 1);
        @(negedge clk);
        send(0, 8'h33, M(0, 1, 23'h123456, 0, 0), 0, RNE,
             E(0, 8'h33, 23'h123456, 0, 0, 0, 0));
        #2 chk("rst2_lat_edge1", out_valid, 0);
        @(negedge clk);
        #2 chk("rst2_lat_edge2", out_valid, 1);
        @(negedge clk);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round_pipe.md
Name: fp_normalize_round_pipe

Overview:
- Parametrised, pipelined successor to the single-precision combinational normalize stage of the FP adder.
- Takes the raw post-add/subtract significand, with carry-out, guard, round and sticky bits, from the adder datapath.
- Normalises it (right shift 1 on carry, left shift by leading-zero count on cancellation) and rounds under a selectable IEEE-754 mode.
- Emits packed sign/exponent/fraction plus exception flags over a 2-stage valid/ready pipeline that feeds result packing.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored fraction width in bits (hidden bit excluded).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_sign  input  1  sign of the raw result.
- in_exp  input  EXP_W  biased exponent of the raw result, before normalisation.
- in_mant  input  MAN_W+4  raw significand {carry, hidden, frac[MAN_W-1:0], guard, round}.
- in_sticky  input  1  OR of all bits below round.
- in_rmode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  result sign.
- out_exp  output  EXP_W  result biased exponent.
- out_frac  output  MAN_W  result fraction.
- out_zero  output  1  result is ±0.
- out_overflow  output  1  exponent overflow occurred.
- out_underflow  output  1  result flushed to zero.
- out_inexact  output  1  result is not exact.

Behaviour:
- Reset (async, any time, including mid-operation):
  - Both stage valid bits clear; all out_* go to 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - In-flight beats are discarded.
- Pipeline: S1 (normalise), S2 (round/register output).
  - Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, when unstalled.
  - Throughput: 1 beat/cycle.
  - Handshake: a beat transfers on a clock edge with valid&&ready.
  - S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads.
  - in_ready = !s1_valid || s2_load. Combinational from out_ready; no skid buffer.
  - Output fields hold stable while out_valid && !out_ready.
  - Maximum occupancy 2 beats. Beats leave in order, none dropped or duplicated.
- S1 normalise (internal exponent signed, EXP_W+2 bits):
  - Zero input (in_mant==0 and in_sticky==0): zero = 1, exponent 0, inexact 0. Sign = in_sign, except RDN forces 1 and other modes force 0 when in_sign differs from the incoming operand-sign context. In this block, sign passes through unmodified.
  - carry = 1: shift right 1, exp+1. Shifted-out round bit ORs into sticky.
  - carry = 0: lz = leading zeros of {hidden, frac, guard, round}. Shift left by lz (zeros shift in), exp - lz.
  - Normalised exponent <= 0, or in_exp == 0 with non-zero mantissa: flush to zero. Sets zero = 1, underflow = 1, inexact = 1, frac = 0. No denormals are produced.
  - After shifting: L = frac[0], G = guard, R = round, S = sticky.
- S2 round:
  - inc is defined per mode:
    - RNE: G && (R || S || L).
    - RTZ: 0.
    - RUP: !sign && (G || R || S).
    - RDN: sign && (G || R || S).
  - frac + inc carrying out of MAN_W bits: frac = 0, exp + 1.
  - inexact = G || R || S (or the underflow flush).
- Overflow (post-round exponent >= 2^EXP_W - 1): overflow = 1, inexact = 1.
  - RNE, or directed mode rounding away from zero for this sign: exp all-ones, frac 0 (inf).
  - Otherwise: exp = 2^EXP_W - 2, frac all-ones (max finite).
- Flags are valid only with out_valid and are held with the data.

Test Plan:
- Carry: exp 0x7F, mant {1,1,0x000000,0,0}, sticky 0, RNE → exp 0x80, frac 0x400000, flags 0, out_valid exactly 2 cycles after accept.
- Cancellation: exp 0x7F, mant {0,0,0x000001,0,0} → exp 0x68, frac 0x000000. With exp 0x10 → zero = 1, underflow = 1, frac 0.
- RNE ties at exp 0x7F, G=1, R=S=0:
  - frac 0x000001 → 0x000002, inexact 1.
  - frac 0x000000 → 0x000000, inexact 1.
  - RTZ, same input → frac unchanged.
  - RUP with sign 0 → frac +1.
- Round carry/overflow: frac 0x7FFFFF, G=R=1, exp 0x7E → exp 0x7F, frac 0. With exp 0xFE:
  - RNE → exp 0xFF, frac 0, overflow 1.
  - RTZ → exp 0xFE, frac 0x7FFFFF, overflow 1.
- Backpressure: 5 back-to-back beats, out_ready low 6 cycles → in_ready drops after 2 accepted, out fields stable; on release all 5 emerge in order, 1/cycle.
- Reset asserted with 2 beats in flight → out_valid = 0 and outputs 0 immediately; the next accepted beat emerges correctly 2 cycles later.
